// File: rtl/score_display_pkg.sv
// Shared types and constants for the score overlay.
// The hiscore colour exists only when SCORE_HISCORE_EN is defined.
package score_display_pkg;
  typedef logic [3:0] bcd_t;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  // Channel 0 is the leftmost byte of the packed constant.
  localparam logic [0:2][7:0] SCORE_COLOR = {8'hFF, 8'hFF, 8'hFF};
`ifdef SCORE_HISCORE_EN
  localparam logic [0:2][7:0] HISCORE_COLOR = {8'h00, 8'hFF, 8'hFF};
`endif

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_OVER  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;
endpackage

// File: rtl/digit_font_rom.sv
// 8x8 digit glyphs for 0-9; row 0 is the top line and bit 7 the leftmost pixel.
// Codes A-F are blank.
module digit_font_rom
  import score_display_pkg::*;
(
  input  bcd_t       digit,
  input  logic [2:0] row,
  output logic [7:0] row_bits
);
  logic [63:0] glyph;

  always_comb begin
    glyph = '0;
    case (digit)
      4'd0:    glyph = 64'h3C666E7666663C00;
      4'd1:    glyph = 64'h1838181818187E00;
      4'd2:    glyph = 64'h3C66060C30607E00;
      4'd3:    glyph = 64'h3C66061C06663C00;
      4'd4:    glyph = 64'h0C1C3C6C7E0C0C00;
      4'd5:    glyph = 64'h7E607C0606663C00;
      4'd6:    glyph = 64'h3C607C6666663C00;
      4'd7:    glyph = 64'h7E060C1830303000;
      4'd8:    glyph = 64'h3C66663C66663C00;
      4'd9:    glyph = 64'h3C66663E060C3800;
      default: glyph = '0;
    endcase
    row_bits = glyph[{~row, 3'b000} +: 8];
  end
endmodule

// File: rtl/score_display.sv
// Kill counter with saturating BCD score and a scaled-glyph overlay layer.
// Define SCORE_HISCORE_EN to add a high-score register, port and second row.
module score_display
  import score_display_pkg::*;
#(
  parameter int SCORE_X        = 16,
  parameter int SCORE_Y        = 16,
  parameter int DIGITS         = 4,
  parameter int SCALE_LOG2     = 1,
  parameter int POINTS_PER_HIT = 1
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    fsync,
  input  logic signed [11:0]      hpos,
  input  logic signed [11:0]      vpos,
  input  logic                    alien_alive,
  input  logic                    game_over,
  output logic [7:0]              pixel [0:2],
  output logic                    active,
  output logic [DIGITS*4-1:0]     score,
`ifdef SCORE_HISCORE_EN
  output logic [DIGITS*4-1:0]     hiscore,
`endif
  output state_t                  dbg_state
);
  localparam int W       = DIGITS * 4;
  localparam int FIELD_W = (DIGITS * GLYPH_W) << SCALE_LOG2;
  localparam int FIELD_H = GLYPH_H << SCALE_LOG2;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t         state_q, state_d;
  logic           alive_q, alive_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   disp_q, disp_d;
  logic [W-1:0]   sum;
  logic           sat;
  logic           kill;

  // Slot 0 is the leftmost (most significant) digit on screen.
  function automatic bcd_t pick_digit(input logic [W-1:0] val, input int slot);
    pick_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot == DIGITS - 1 - i) pick_digit = val[i*4 +: 4];
    end
  endfunction

  always_comb begin : bcd_add
    logic [4:0] acc;
    logic [3:0] carry;
    acc   = '0;
    carry = 4'(POINTS_PER_HIT);
    sum   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      acc = {1'b0, score_q[i*4 +: 4]} + {1'b0, carry};
      if (acc > 5'd9) begin
        sum[i*4 +: 4] = 4'(acc - 5'd10);
        carry         = 4'd1;
      end else begin
        sum[i*4 +: 4] = acc[3:0];
        carry         = 4'd0;
      end
    end
    sat = (carry != 4'd0);
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    disp_d  = disp_q;
    alive_d = alien_alive;
    // A kill racing game_over, or landing in OVER/CLEAR, is dropped.
    kill = alive_q & ~alien_alive & ~game_over & (state_q == ST_PLAY);
    case (state_q)
      ST_PLAY:  if (game_over) state_d = ST_OVER;
      ST_OVER:  if (!game_over) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_PLAY;
      default:  state_d = ST_PLAY;
    endcase
    if (state_q == ST_CLEAR) score_d = '0;
    else if (kill)           score_d = sat ? ALL_NINES : sum;
    if (fsync) disp_d = score_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q <= ST_PLAY;
      alive_q <= 1'b1;
      score_q <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      score_q <= score_d;
      disp_q  <= disp_d;
    end
  end

  assign score     = score_q;
  assign dbg_state = state_q;

  // Score row geometry; offsets are widened so negative positions stay negative.
  logic signed [13:0] dx, dy;
  logic               in_field, score_lit;
  bcd_t               score_digit;
  logic [7:0]         score_bits;

  assign dx = {{2{hpos[11]}}, hpos} - 14'(SCORE_X);
  assign dy = {{2{vpos[11]}}, vpos} - 14'(SCORE_Y);
  assign in_field = !dx[13] && (dx[12:0] < 13'(FIELD_W)) &&
                    !dy[13] && (dy[12:0] < 13'(FIELD_H));
  assign score_digit = pick_digit(disp_q, int'(dx[12:SCALE_LOG2+3]));

  digit_font_rom u_score_rom (
    .digit    (score_digit),
    .row      (dy[SCALE_LOG2 +: 3]),
    .row_bits (score_bits)
  );

  assign score_lit = in_field & score_bits[~dx[SCALE_LOG2 +: 3]];

`ifdef SCORE_HISCORE_EN
  localparam int HI_Y = SCORE_Y + FIELD_H + 2;

  logic [W-1:0]       hiscore_q, hiscore_d;
  logic signed [13:0] hy;
  logic               in_hi, hi_lit;
  bcd_t               hi_digit;
  logic [7:0]         hi_bits;

  // Packed BCD of equal width orders the same as its decimal value.
  always_comb begin
    hiscore_d = hiscore_q;
    if (state_q == ST_PLAY && game_over && score_q > hiscore_q) hiscore_d = score_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) hiscore_q <= '0;
    else     hiscore_q <= hiscore_d;
  end

  assign hiscore = hiscore_q;
  assign hy = {{2{vpos[11]}}, vpos} - 14'(HI_Y);
  assign in_hi = !dx[13] && (dx[12:0] < 13'(FIELD_W)) &&
                 !hy[13] && (hy[12:0] < 13'(FIELD_H));
  assign hi_digit = pick_digit(hiscore_q, int'(dx[12:SCALE_LOG2+3]));

  digit_font_rom u_hi_rom (
    .digit    (hi_digit),
    .row      (hy[SCALE_LOG2 +: 3]),
    .row_bits (hi_bits)
  );

  assign hi_lit = in_hi & hi_bits[~dx[SCALE_LOG2 +: 3]];
`endif

  always_comb begin
    active = 1'b0;
    for (int c = 0; c < 3; c++) pixel[c] = 8'h00;
    if (!rst && score_lit) begin
      active = 1'b1;
      for (int c = 0; c < 3; c++) pixel[c] = SCORE_COLOR[c];
    end
`ifdef SCORE_HISCORE_EN
    else if (!rst && hi_lit) begin
      active = 1'b1;
      for (int c = 0; c < 3; c++) pixel[c] = HISCORE_COLOR[c];
    end
`endif
  end
endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: two instances (default and DIGITS=2/7 points) against
// an arithmetic model of score, freeze/clear behaviour and glyph rendering.
module tb_score_display;
  localparam int P_X[2] = '{16, 3};
  localparam int P_Y[2] = '{16, 2};
  localparam int P_D[2] = '{4, 2};
  localparam int P_S[2] = '{1, 0};
  localparam int P_P[2] = '{1, 7};

  logic clk = 1'b0;
  logic rst, fsync, alien_alive, game_over;
  logic signed [11:0] hpos, vpos;
  logic [7:0]  pix_a [0:2];
  logic [7:0]  pix_b [0:2];
  logic        act_a, act_b;
  logic [15:0] score_a;
  logic [7:0]  score_b;
  logic [1:0]  st_a, st_b;
`ifdef SCORE_HISCORE_EN
  logic [15:0] hi_a;
  logic [7:0]  hi_b;
`endif

  always #5 clk = ~clk;

  score_display #(.SCORE_X(16), .SCORE_Y(16), .DIGITS(4), .SCALE_LOG2(1), .POINTS_PER_HIT(1)) u_dut_a (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .alien_alive(alien_alive), .game_over(game_over),
    .pixel(pix_a), .active(act_a), .score(score_a),
`ifdef SCORE_HISCORE_EN
    .hiscore(hi_a),
`endif
    .dbg_state(st_a)
  );

  score_display #(.SCORE_X(3), .SCORE_Y(2), .DIGITS(2), .SCALE_LOG2(0), .POINTS_PER_HIT(7)) u_dut_b (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .alien_alive(alien_alive), .game_over(game_over),
    .pixel(pix_b), .active(act_b), .score(score_b),
`ifdef SCORE_HISCORE_EN
    .hiscore(hi_b),
`endif
    .dbg_state(st_b)
  );

  logic [63:0] font_tbl [0:9] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00,
    64'h3C66061C06663C00, 64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
    64'h3C607C6666663C00, 64'h7E060C1830303000, 64'h3C66663C66663C00,
    64'h3C66663E060C3800};

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model: decimal scores, mode 0 = playing, 1 = game over, 2 = clearing.
  int m_score[2], m_disp[2], m_hi[2];
  int m_mode;
  bit m_alive;
  bit m_kill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int max_score(input int i);
    int m;
    m = 1;
    for (int k = 0; k < P_D[i]; k++) m = m * 10;
    return m - 1;
  endfunction

  function automatic bit glyph_lit(input int i, input int hp, input int vp, input int top, input int value);
    int sc, dx, dy, px, py, pw, dig;
    sc = 1 << P_S[i];
    dx = hp - P_X[i];
    dy = vp - top;
    if (dx < 0 || dy < 0 || dx >= P_D[i] * 8 * sc || dy >= 8 * sc) return 1'b0;
    px = dx / sc;
    py = dy / sc;
    pw = 1;
    for (int k = 0; k < P_D[i] - 1 - px / 8; k++) pw = pw * 10;
    dig = (value / pw) % 10;
    return font_tbl[dig][63 - 8 * py - px % 8];
  endfunction

  function automatic logic [23:0] exp_pix(input int i, input int hp, input int vp);
    if (rst) return 24'h000000;
    if (glyph_lit(i, hp, vp, P_Y[i], m_disp[i])) return 24'hFFFFFF;
`ifdef SCORE_HISCORE_EN
    if (glyph_lit(i, hp, vp, P_Y[i] + (8 << P_S[i]) + 2, m_hi[i])) return 24'h00FFFF;
`endif
    return 24'h000000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_score[i] = 0;
        m_disp[i]  = 0;
        m_hi[i]    = 0;
      end
      m_mode  = 0;
      m_alive = 1'b1;
    end else begin
      m_kill = m_alive && !alien_alive && !game_over && (m_mode == 0);
      for (int i = 0; i < 2; i++) begin
        if (fsync) m_disp[i] = m_score[i];
        if (m_mode == 0 && game_over && m_score[i] > m_hi[i]) m_hi[i] = m_score[i];
        if (m_mode == 2) m_score[i] = 0;
        else if (m_kill) m_score[i] = (m_score[i] + P_P[i] > max_score(i)) ? max_score(i) : m_score[i] + P_P[i];
      end
      if (m_mode == 0 && game_over)       m_mode = 1;
      else if (m_mode == 1 && !game_over) m_mode = 2;
      else if (m_mode == 2)               m_mode = 0;
      m_alive = alien_alive;
    end
  end

  task automatic cmp_inst(input int i, input logic [23:0] sc, input logic act,
                          input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                          input logic [1:0] st);
    logic [23:0] ep;
    ep = exp_pix(i, int'(hpos), int'(vpos));
    check($sformatf("score%0d", i), 32'(sc), 32'(to_bcd(m_score[i])));
    check($sformatf("state%0d", i), 32'(st), 32'(m_mode));
    check($sformatf("active%0d(%0d,%0d)", i, hpos, vpos), 32'(act), 32'(ep != 24'h0));
    check($sformatf("pixel%0d(%0d,%0d)", i, hpos, vpos), {8'h00, p0, p1, p2}, 32'(ep));
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      cmp_inst(0, 24'(score_a), act_a, pix_a[0], pix_a[1], pix_a[2], st_a);
      cmp_inst(1, 24'(score_b), act_b, pix_b[0], pix_b[1], pix_b[2], st_b);
`ifdef SCORE_HISCORE_EN
      check("hiscore0", 32'(hi_a), 32'(to_bcd(m_hi[0])));
      check("hiscore1", 32'(hi_b), 32'(to_bcd(m_hi[1])));
`endif
    end
  end

  task automatic do_kill();
    @(negedge clk);
    alien_alive = 1'b0;
    @(negedge clk);
    alien_alive = 1'b1;
  endtask

  task automatic pulse_fsync();
    @(negedge clk);
    fsync = 1'b1;
    @(negedge clk);
    fsync = 1'b0;
  endtask

  task automatic probe(input string name, input int hp, input int vp, input bit exp);
    @(negedge clk);
    hpos = 12'(hp);
    vpos = 12'(vp);
    #3;
    check(name, 32'(act_a), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; fsync = 1'b0; alien_alive = 1'b1; game_over = 1'b0;
    hpos = 12'sd20; vpos = 12'sd16;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    #3 check("lit_in_reset", 32'(act_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("reset_score", 32'(score_a), 32'h0);
    check("reset_state", 32'(st_a), 32'd0);
    check("zero_glyph_after_reset", 32'(act_a), 32'd1);

    // Three kills; digit 0 column 1 row 3 is lit for '0' and dark for '3'.
    hpos = 12'sd66; vpos = 12'sd22;
    for (int k = 1; k <= 3; k++) begin
      do_kill();
      #3 check($sformatf("kill_%0d", k), 32'(score_a), 32'(k));
    end
    check("display_before_fsync", 32'(act_a), 32'd1);
    pulse_fsync();
    #3 check("display_after_fsync", 32'(act_a), 32'd0);

    // BCD carry and saturation of the two-digit instance.
    for (int k = 0; k < 7; k++) do_kill();
    #3;
    check("carry_a", 32'(score_a), 32'h0010);
    check("carry_b", 32'(score_b), 32'h70);
    for (int k = 0; k < 6; k++) do_kill();
    #3;
    check("sixteen_a", 32'(score_a), 32'h0016);
    check("saturate_b", 32'(score_b), 32'h99);
    do_kill();
    #3 check("hold_b", 32'(score_b), 32'h99);

    // Sweep the first glyph lines across and just beyond the field.
    pulse_fsync();
    for (int y = 16; y < 20; y++)
      for (int x = 14; x <= 16 + 64 + 1; x++) begin
        @(negedge clk);
        hpos = 12'(x);
        vpos = 12'(y);
      end
    probe("edge_left", 15, 16, 1'b0);
    probe("edge_right", 16 + 64, 16, 1'b0);
    probe("zero_col0", 16, 16, 1'b0);
    probe("zero_col2", 20, 16, 1'b1);
    probe("negative_pos", -4, -4, 1'b0);

    // Freeze on game over, then clear.
    @(negedge clk);
    game_over = 1'b1;
    alien_alive = 1'b0;
    @(negedge clk);
    alien_alive = 1'b1;
    #3;
    check("kill_with_game_over", 32'(score_a), 32'h0017);
    check("state_over", 32'(st_a), 32'd1);
    for (int k = 0; k < 3; k++) do_kill();
    #3 check("frozen", 32'(score_a), 32'h0017);
    @(negedge clk);
    game_over = 1'b0;
    @(negedge clk);
    alien_alive = 1'b0;
    #3;
    check("state_clear", 32'(st_a), 32'd2);
    check("clear_pending", 32'(score_a), 32'h0017);
    @(negedge clk);
    alien_alive = 1'b1;
    #3;
    check("cleared", 32'(score_a), 32'h0);
    check("clear_kill_dropped", 32'(score_b), 32'h0);

    // Randomised play with occasional resets, including one mid-frame.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst = (cyc == 2000) || ($urandom_range(0, 1499) == 0);
      alien_alive = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0) game_over = ~game_over;
      fsync = ($urandom_range(0, 15) == 0);
      hpos = 12'(int'($urandom_range(0, 150)) - 20);
      vpos = 12'(int'($urandom_range(0, 70)) - 10);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
